// File: rtl/smoke_rpc_ep_if.sv
// Handshake bundle for the RPC endpoint: host request, DUT call/return and host response.
interface smoke_rpc_ep_if #(
    parameter int unsigned DATA_W = 32
);
    // Host request channel
    logic              req_valid;
    logic              req_ready;
    logic [7:0]        req_id;
    logic [DATA_W-1:0] req_data;
    // DUT call channel
    logic              call_valid;
    logic              call_ready;
    logic [7:0]        call_id;
    logic [DATA_W-1:0] call_data;
    // DUT return pulse (no backpressure)
    logic              ret_valid;
    logic [DATA_W-1:0] ret_data;
    // Host response channel
    logic              rsp_valid;
    logic              rsp_ready;
    logic [7:0]        rsp_id;
    logic [DATA_W-1:0] rsp_data;
    logic [1:0]        rsp_status;

    // Endpoint side
    modport slave (
        input  req_valid, req_id, req_data, call_ready, ret_valid, ret_data, rsp_ready,
        output req_ready, call_valid, call_id, call_data, rsp_valid, rsp_id, rsp_data,
               rsp_status
    );

    // Host / called-DUT side
    modport master (
        output req_valid, req_id, req_data, call_ready, ret_valid, ret_data, rsp_ready,
        input  req_ready, call_valid, call_id, call_data, rsp_valid, rsp_id, rsp_data,
               rsp_status
    );
endinterface

// File: rtl/smoke_rpc_ep.sv
// RPC endpoint: queues host requests, issues each as a call, waits for a return pulse
// (or times out) and hands the result back on the response channel, one call at a time.
module smoke_rpc_ep #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    smoke_rpc_ep_if.slave          bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy,
    output logic                   err_stray
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned TmrW = $clog2(TIMEOUT) + 1;
    localparam int unsigned EntW = 8 + DATA_W;

    localparam logic [CntW-1:0] DepthC  = CntW'(DEPTH);
    localparam logic [TmrW-1:0] TmoLast = TmrW'(TIMEOUT - 1);

    localparam logic [1:0] StatusOk      = 2'b00;
    localparam logic [1:0] StatusTimeout = 2'b01;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e            state_q, state_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [TmrW-1:0]   timer_q, timer_d;
    logic [7:0]        call_id_q, call_id_d;
    logic [DATA_W-1:0] call_data_q, call_data_d;
    logic [7:0]        rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]        rsp_status_q, rsp_status_d;
    logic              err_stray_q, err_stray_d;

    logic              push;
    logic              pop;
    logic [EntW-1:0]   mem_q [DEPTH];
    logic [EntW-1:0]   head;

    // Ready depends only on registered occupancy; forced low while reset is held.
    assign bus.req_ready = reset_n && (count_q < DepthC);
    assign push          = bus.req_valid && bus.req_ready;
    assign head          = mem_q[rd_ptr_q];

    assign count          = count_q;
    assign err_stray      = err_stray_q;
    assign bus.call_id    = call_id_q;
    assign bus.call_data  = call_data_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_status = rsp_status_q;

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.req_id, bus.req_data};
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; a return pulse beats a coincident timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (count_q != '0) state_d = StIssue;
            StIssue: if (bus.call_ready) state_d = StWait;
            StWait:  if (bus.ret_valid || (timer_q == TmoLast)) state_d = StResp;
            StResp:  if (bus.rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs decoded from the registered state; popping only from IDLE gives the bubble.
    always_comb begin
        pop            = (state_q == StIdle) && (count_q != '0);
        bus.call_valid = (state_q == StIssue);
        bus.rsp_valid  = (state_q == StResp);
        busy           = (state_q != StIdle);
    end

    // FIFO pointers and occupancy next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Call/response holding registers, wait timer and sticky stray-return flag.
    always_comb begin
        call_id_d    = call_id_q;
        call_data_d  = call_data_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;
        timer_d      = timer_q;
        err_stray_d  = err_stray_q || (bus.ret_valid && (state_q != StWait));
        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    {call_id_d, call_data_d} = head;
                end
            end
            StIssue: begin
                if (bus.call_ready) begin
                    timer_d = '0;
                end
            end
            StWait: begin
                if (bus.ret_valid) begin
                    rsp_id_d     = call_id_q;
                    rsp_data_d   = bus.ret_data;
                    rsp_status_d = StatusOk;
                end else if (timer_q == TmoLast) begin
                    rsp_id_d     = call_id_q;
                    rsp_data_d   = '0;
                    rsp_status_d = StatusTimeout;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            timer_q      <= '0;
            call_id_q    <= '0;
            call_data_q  <= '0;
            rsp_id_q     <= '0;
            rsp_data_q   <= '0;
            rsp_status_q <= '0;
            err_stray_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            timer_q      <= timer_d;
            call_id_q    <= call_id_d;
            call_data_q  <= call_data_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
            err_stray_q  <= err_stray_d;
        end
    end
endmodule

// File: doc/smoke_rpc_ep.md
SMOKE_RPC_EP -- requirements
Module: smoke_rpc_ep

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of call argument and return data.
REQ-002 SHALL have parameter DEPTH, default 4: request FIFO entries, a power of 2 and at least 2.
REQ-003 SHALL have parameter TIMEOUT, default 16: maximum WAIT cycles before a timeout response.
REQ-004 SHALL have ports: clock in 1, the single clock; reset_n in 1, reset (asynchronous, active-low).
REQ-005 SHALL have ports: req_valid in 1; req_ready out 1; req_id in 8; req_data in DATA_W: host request channel.
REQ-006 SHALL have ports: call_valid out 1; call_ready in 1; call_id out 8; call_data out DATA_W: DUT call channel.
REQ-007 SHALL have ports: ret_valid in 1; ret_data in DATA_W: DUT return, single-cycle pulse, no backpressure.
REQ-008 SHALL have ports: rsp_valid out 1; rsp_ready in 1; rsp_id out 8; rsp_data out DATA_W; rsp_status out 2 (00 OK, 01 TIMEOUT).
REQ-009 SHALL have ports: count out clog2(DEPTH)+1, FIFO occupancy; busy out 1, FSM not in IDLE; err_stray out 1, sticky.

Function
REQ-010 SHALL push {req_id, req_data} into the FIFO on each rising edge with req_valid && req_ready.
REQ-011 SHALL drive req_ready = (count < DEPTH) combinationally, forced 0 while reset_n is low; a full FIFO accepts nothing, even when a pop occurs in the same cycle.
REQ-012 SHALL update count by +1 on push only, -1 on pop only, and leave it unchanged on simultaneous push and pop.
REQ-013 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-014 IDLE: when count > 0 at an edge, SHALL pop the head into the call holding registers and go to ISSUE.
REQ-015 Pop latency: a request pushed at edge k into an empty FIFO with the FSM in IDLE SHALL pop at edge k+1, with call_valid registered high after edge k+1.
REQ-016 ISSUE: SHALL hold call_valid=1 with call_id and call_data stable until call_ready, then go to WAIT and clear the timer to 0.
REQ-017 WAIT: on ret_valid SHALL capture ret_data into rsp_data, set rsp_status=00 and go to RESP.
REQ-018 WAIT without ret_valid: SHALL increment the timer; when timer == TIMEOUT-1, SHALL go to RESP with rsp_status=01 and rsp_data=0, so WAIT lasts at most TIMEOUT cycles.
REQ-019 If ret_valid coincides with the timeout cycle, ret_valid SHALL win and give status OK.
REQ-020 The timer SHALL be clog2(TIMEOUT)+1 bits and SHALL never wrap.
REQ-021 RESP: SHALL hold rsp_valid=1 with rsp_id equal to the issued call_id; on rsp_ready SHALL go to IDLE.
REQ-022 On return to IDLE, SHALL not pop in that same edge; the next pop is at the following edge, a 1-cycle bubble.
REQ-023 ret_valid in any state other than WAIT SHALL be ignored for data and SHALL set err_stray=1 until reset.
REQ-024 busy SHALL equal (state != IDLE), registered.
REQ-025 Pushes SHALL continue in every FSM state while space remains; FIFO order SHALL be strictly preserved and the FIFO pointers SHALL wrap modulo DEPTH.

Reset
REQ-026 reset_n low SHALL immediately reset: state IDLE, FIFO pointers, count and timer to 0, and call_valid, rsp_valid, busy and err_stray to 0.
REQ-027 Reset SHALL clear call_id, call_data, rsp_id, rsp_data and rsp_status to 0.
REQ-028 Reset asserted mid-transaction SHALL discard all queued and in-flight requests, with no response emitted.
REQ-029 Outputs SHALL be defined starting from the first edge after reset_n rises.

Verification
REQ-030 Single call: push id=0x01, data=0xA5A5A5A5 with call_ready=1 and ret_valid 3 cycles later with ret_data=0x12345678 -> call_valid high after edge k+1; rsp_id=0x01, rsp_data=0x12345678, rsp_status=00.
REQ-031 Timeout: call accepted, ret_valid never asserted -> rsp_status=01, rsp_data=0, rsp_valid rising exactly TIMEOUT=16 cycles after WAIT entry.
REQ-032 Return on the final cycle: ret_valid in the cycle where timer==15 -> rsp_status=00 with the returned data.
REQ-033 Full FIFO: 5 back-to-back pushes with call_ready=0 -> the first pops; the next 4 fill the FIFO, req_ready=0 at count=4, and ids come out in push order.
REQ-034 Stray return and backpressure: ret_valid in IDLE -> err_stray=1, no rsp; rsp_ready held 0 for 5 cycles -> rsp_valid and rsp fields stay stable.
REQ-035 Reset during WAIT with 2 entries queued -> count=0, busy=0, rsp_valid=0 immediately; no response after release.
